// File: rtl/load_store_unit.sv
// load_store_unit
//   Bridges single CPU load/store requests onto a word-wide DMEM port with a
//   combinational read path. Loads select and extend the addressed lane;
//   word stores write directly; byte/halfword stores read-modify-write.
//
//   Optional feature macro: LSU_MISALIGN_TRAP_EN
//     defined   -> misaligned requests skip the memory access and complete
//                  after one cycle with resp_misaligned=1 and resp_rdata=0.
//     undefined -> low address bits are ignored for halfword/word accesses
//                  and resp_misaligned is always 0.
//
//   Ports
//     clk, rst            clock, asynchronous active-high reset
//     req_valid/ready     request handshake (ready only in IDLE)
//     req_write           1 = store, 0 = load
//     req_size            00 byte, 01 halfword, 10/11 word
//     req_unsigned        loads: 1 = zero-extend, 0 = sign-extend
//     req_addr            byte address (ADDR_W bits)
//     req_wdata           right-justified store data
//     resp_valid          one-cycle completion pulse
//     resp_rdata          extended load data (0 for stores), held until next response
//     resp_misaligned     completed access was misaligned, held until next response
//     memwrite            DMEM word write enable
//     DMEM_address        DMEM word-aligned byte address
//     DMEM_data_in        DMEM write word
//     readdata            DMEM read word at DMEM_address

module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_misaligned,
  output logic              memwrite,
  output logic [ADDR_W-1:0] DMEM_address,
  output logic [31:0]       DMEM_data_in,
  input  logic [31:0]       readdata
);

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_nextState;

  logic              r_write;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_merged;
  logic [31:0]       r_rdata;
  logic              r_misaligned;

  logic              w_reqMisaligned;
  logic              w_trap;
  logic [ADDR_W-1:0] w_wordAddr;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_loadData;
  logic [31:0]       w_merged;

  // Misalignment is judged on the incoming request so a trapping request can
  // bypass the memory phases straight from IDLE.
  assign w_reqMisaligned = ((req_size == 2'b01) && req_addr[0]) ||
                           (req_size[1] && (req_addr[1:0] != 2'b00));
  assign w_trap          = TrapEn && w_reqMisaligned;

  assign w_wordAddr      = {r_addr[ADDR_W-1:2], 2'b00};

  assign resp_rdata      = r_rdata;
  assign resp_misaligned = r_misaligned;

  // Lane extraction and extension for loads; halfword lane uses only addr[1]
  // so an odd halfword address silently aligns down.
  always_comb begin
    w_byte = 8'h00;
    case (r_addr[1:0])
      2'b00:   w_byte = readdata[7:0];
      2'b01:   w_byte = readdata[15:8];
      2'b10:   w_byte = readdata[23:16];
      default: w_byte = readdata[31:24];
    endcase
    w_half = r_addr[1] ? readdata[31:16] : readdata[15:0];
    case (r_size)
      2'b00:   w_loadData = r_unsigned ? {24'h000000, w_byte}
                                       : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_loadData = r_unsigned ? {16'h0000, w_half}
                                       : {{16{w_half[15]}}, w_half};
      default: w_loadData = readdata;
    endcase
  end

  // Sub-word store merge: the current memory word with only the target lane
  // replaced by the low bits of the store data.
  always_comb begin
    w_merged = readdata;
    if (r_size == 2'b00) begin
      case (r_addr[1:0])
        2'b00:   w_merged[7:0]   = r_wdata[7:0];
        2'b01:   w_merged[15:8]  = r_wdata[7:0];
        2'b10:   w_merged[23:16] = r_wdata[7:0];
        default: w_merged[31:24] = r_wdata[7:0];
      endcase
    end else if (r_addr[1]) begin
      w_merged[31:16] = r_wdata[15:0];
    end else begin
      w_merged[15:0] = r_wdata[15:0];
    end
  end

  // State register; reset drops any in-flight access immediately so no
  // write enable can reach DMEM after the reset edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and DMEM-side outputs. Word stores write during ACCESS;
  // sub-word stores read in ACCESS and write the merged word in WRITE.
  always_comb begin
    w_nextState  = r_state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    memwrite     = 1'b0;
    DMEM_address = '0;
    DMEM_data_in = 32'h0000_0000;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_nextState = w_trap ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        DMEM_address = w_wordAddr;
        if (r_write && r_size[1]) begin
          memwrite     = 1'b1;
          DMEM_data_in = r_wdata;
          w_nextState  = RESP;
        end else if (r_write) begin
          w_nextState = WRITE;
        end else begin
          w_nextState = RESP;
        end
      end
      WRITE: begin
        DMEM_address = w_wordAddr;
        memwrite     = 1'b1;
        DMEM_data_in = r_merged;
        w_nextState  = RESP;
      end
      RESP: begin
        resp_valid  = 1'b1;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Request capture, merge buffer and response registers. Response values
  // are only updated on the edge entering RESP so they hold between responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_write      <= 1'b0;
      r_size       <= 2'b00;
      r_unsigned   <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= 32'h0000_0000;
      r_merged     <= 32'h0000_0000;
      r_rdata      <= 32'h0000_0000;
      r_misaligned <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_write    <= req_write;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            if (w_trap) begin
              r_rdata      <= 32'h0000_0000;
              r_misaligned <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (!r_write) begin
            r_rdata      <= w_loadData;
            r_misaligned <= 1'b0;
          end else if (r_size[1]) begin
            r_rdata      <= 32'h0000_0000;
            r_misaligned <= 1'b0;
          end else begin
            r_merged <= w_merged;
          end
        end
        WRITE: begin
          r_rdata      <= 32'h0000_0000;
          r_misaligned <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//   Self-checking bench for load_store_unit. A word-wide DMEM array serves
//   the combinational read port and takes writes on memwrite. A byte-level
//   reference memory and a latency counter predict every output each cycle;
//   directed requests pin the predictions with hand-computed literals, then a
//   randomized phase (with occasional reset pulses) exercises the rest.
//   Honours LSU_MISALIGN_TRAP_EN the same way the design does.

module tb_load_store_unit;

  localparam int ADDR_W = 32;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_misaligned;
  logic              memwrite;
  logic [ADDR_W-1:0] DMEM_address;
  logic [31:0]       DMEM_data_in;
  logic [31:0]       readdata;

  logic [31:0] memArr [0:63];
  logic [7:0]  refBytes [0:255];

  int nChecks = 0;
  int nPass   = 0;
  bit cmpEn   = 1'b0;

  // Reference model state: busy flag, cycles left until the response cycle,
  // and the prediction for the request in flight.
  bit          mBusy     = 1'b0;
  int          mLeft     = 0;
  bit          pWrite    = 1'b0;
  bit          pMis      = 1'b0;
  logic [31:0] pRdata    = 32'h0;
  logic [31:0] pWord     = 32'h0;
  int          pWordAddr = 0;
  logic [7:0]  pBytes [0:3];
  logic [31:0] heldRdata = 32'h0;
  bit          heldMis   = 1'b0;

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_size        (req_size),
    .req_unsigned    (req_unsigned),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_misaligned (resp_misaligned),
    .memwrite        (memwrite),
    .DMEM_address    (DMEM_address),
    .DMEM_data_in    (DMEM_data_in),
    .readdata        (readdata)
  );

  always #5 clk = ~clk;

  // DMEM: combinational read, synchronous word write.
  assign readdata = memArr[DMEM_address[7:2]];
  always @(posedge clk) begin
    if (memwrite) memArr[DMEM_address[7:2]] <= DMEM_data_in;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual === expected) nPass++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  // Predict the outcome of an accepted request from byte-level memory:
  // access width 1/2/4 bytes, address aligned down to the width, little-endian.
  task automatic modelAccept();
    int     sz, nb, ea, wb;
    bit     mis;
    longint v;
    sz  = (req_size == 2'b11) ? 2 : int'(req_size);
    nb  = 1 << sz;
    mis = (int'(req_addr[7:0]) % nb) != 0;
    ea  = int'(req_addr[7:0]) & ~(nb - 1);
    wb  = ea & ~3;
    mBusy = 1'b1; pMis = 1'b0; pWrite = 1'b0; pRdata = 32'h0; pWordAddr = wb;
    if (TrapEn && mis) begin
      pMis  = 1'b1;
      mLeft = 0;
    end else if (req_write) begin
      for (int k = 0; k < 4; k++) pBytes[k] = refBytes[wb + k];
      for (int k = 0; k < nb; k++) pBytes[(ea - wb) + k] = 8'(req_wdata >> (8 * k));
      pWord  = {pBytes[3], pBytes[2], pBytes[1], pBytes[0]};
      pWrite = 1'b1;
      mLeft  = (nb == 4) ? 1 : 2;
    end else begin
      v = 0;
      for (int k = 0; k < nb; k++) v += longint'(refBytes[ea + k]) << (8 * k);
      if (!req_unsigned && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
        v -= longint'(1) << (8 * nb);
      pRdata = 32'(v);
      mLeft  = 1;
    end
    if (mLeft == 0) begin
      heldRdata = pRdata;
      heldMis   = pMis;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mBusy = 1'b0; mLeft = 0; pWrite = 1'b0;
      heldRdata = 32'h0; heldMis = 1'b0;
    end else if (mBusy) begin
      if (mLeft == 1 && pWrite)
        for (int k = 0; k < 4; k++) refBytes[pWordAddr + k] = pBytes[k];
      if (mLeft == 0) begin
        mBusy = 1'b0;
      end else begin
        mLeft--;
        if (mLeft == 0) begin
          heldRdata = pRdata;
          heldMis   = pMis;
        end
      end
    end else if (req_valid) begin
      modelAccept();
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmpEn) begin
      checkOutput("req_ready", 32'(req_ready), 32'(!mBusy));
      checkOutput("resp_valid", 32'(resp_valid), 32'(mBusy && mLeft == 0));
      checkOutput("memwrite", 32'(memwrite), 32'(mBusy && mLeft == 1 && pWrite));
      checkOutput("dmem_addr_low", 32'(DMEM_address[1:0]), 32'h0);
      if (!mBusy) begin
        checkOutput("idle_dmem_addr", DMEM_address, 32'h0);
        checkOutput("idle_dmem_data", DMEM_data_in, 32'h0);
      end else if (mLeft >= 1) begin
        checkOutput("dmem_addr", DMEM_address, 32'(pWordAddr));
      end
      if (mBusy && mLeft == 1 && pWrite)
        checkOutput("dmem_data", DMEM_data_in, pWord);
      checkOutput("resp_rdata", resp_rdata, heldRdata);
      checkOutput("resp_misaligned", 32'(resp_misaligned), 32'(heldMis));
    end
  end

  // Present one request and hold it until the unit accepts it.
  task automatic applyStimulus(input logic w, input logic [1:0] sz, input logic u,
                               input logic [31:0] a, input logic [31:0] wd);
    int guard;
    guard = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = wd;
    @(negedge clk);
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) checkOutput("accept_timeout", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Count cycles from acceptance until resp_valid, bounded.
  task automatic awaitResp(output int lat, output int mwCycles);
    lat = 1; mwCycles = 0;
    @(negedge clk);
    while (!resp_valid && lat < 10) begin
      if (memwrite) mwCycles++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic doReq(input string name, input logic w, input logic [1:0] sz,
                       input logic u, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] expR, input int expLat, input int expMis,
                       input int expMw);
    int lat, mw;
    applyStimulus(w, sz, u, a, wd);
    awaitResp(lat, mw);
    checkOutput({name, ".rdata"}, resp_rdata, expR);
    checkOutput({name, ".latency"}, 32'(lat), 32'(expLat));
    checkOutput({name, ".misaligned"}, 32'(resp_misaligned), 32'(expMis));
    checkOutput({name, ".writeCycles"}, 32'(mw), 32'(expMw));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int nResp;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = 32'h0;
    rst = 1'b1;
    for (int i = 0; i < 64; i++) begin
      memArr[i] = $urandom;
      for (int k = 0; k < 4; k++) refBytes[4 * i + k] = 8'(memArr[i] >> (8 * k));
    end

    @(posedge clk); #1;
    cmpEn = 1'b1;
    @(negedge clk);
    checkOutput("reset.req_ready", 32'(req_ready), 32'h1);
    checkOutput("reset.resp_valid", 32'(resp_valid), 32'h0);
    checkOutput("reset.memwrite", 32'(memwrite), 32'h0);
    checkOutput("reset.dmem_addr", DMEM_address, 32'h0);
    checkOutput("reset.dmem_data", DMEM_data_in, 32'h0);
    checkOutput("reset.rdata", resp_rdata, 32'h0);
    checkOutput("reset.misaligned", 32'(resp_misaligned), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] directed requests");
    doReq("sw10", 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 2, 0, 1);
    doReq("lw10", 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 2, 0, 0);
    doReq("lw10rsv", 0, 2'b11, 0, 32'h10, 32'h0, 32'hDEADBEEF, 2, 0, 0);
    doReq("sw08", 1, 2'b10, 0, 32'h08, 32'h11223344, 32'h0, 2, 0, 1);
    doReq("lb0B", 0, 2'b00, 0, 32'h0B, 32'h0, 32'h00000011, 2, 0, 0);
    doReq("sb09", 1, 2'b00, 0, 32'h09, 32'hFFFFFFAA, 32'h0, 3, 0, 1);
    doReq("lw08", 0, 2'b10, 0, 32'h08, 32'h0, 32'h1122AA44, 2, 0, 0);
    doReq("sw04", 1, 2'b10, 0, 32'h04, 32'h8000FF7F, 32'h0, 2, 0, 1);
    doReq("lh06", 0, 2'b01, 0, 32'h06, 32'h0, 32'hFFFF8000, 2, 0, 0);
    doReq("lhu06", 0, 2'b01, 1, 32'h06, 32'h0, 32'h00008000, 2, 0, 0);
    doReq("lb04", 0, 2'b00, 0, 32'h04, 32'h0, 32'h0000007F, 2, 0, 0);
    doReq("lb05", 0, 2'b00, 0, 32'h05, 32'h0, 32'hFFFFFFFF, 2, 0, 0);
    doReq("sw00", 1, 2'b10, 0, 32'h00, 32'hA5A55A5A, 32'h0, 2, 0, 1);
    doReq("lh03", 0, 2'b01, 0, 32'h03, 32'h0, TrapEn ? 32'h0 : 32'hFFFFA5A5,
          TrapEn ? 1 : 2, TrapEn ? 1 : 0, 0);

    $display("[TB] reset during sub-word write");
    doReq("sw0C", 1, 2'b10, 0, 32'h0C, 32'hCAFEF00D, 32'h0, 2, 0, 1);
    applyStimulus(1, 2'b01, 0, 32'h0C, 32'h00001234);
    @(negedge clk);
    @(negedge clk);
    checkOutput("rstAbort.inWrite", 32'(memwrite), 32'h1);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    nResp = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) nResp++;
    end
    checkOutput("rstAbort.noResp", 32'(nResp), 32'h0);
    checkOutput("rstAbort.ready", 32'(req_ready), 32'h1);
    checkOutput("rstAbort.memUnchanged", memArr[3], 32'hCAFEF00D);
    doReq("lw0C", 0, 2'b10, 0, 32'h0C, 32'h0, 32'hCAFEF00D, 2, 0, 0);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 199) == 0) rst = 1'b1;
      req_valid    = ($urandom_range(0, 3) != 0);
      req_write    = 1'($urandom_range(0, 1));
      req_size     = 2'($urandom_range(0, 3));
      req_unsigned = 1'($urandom_range(0, 1));
      req_addr     = {24'h000000, 8'($urandom_range(0, 255))};
      req_wdata    = $urandom;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = 1'b0;
    repeat (6) @(negedge clk);
    cmpEn = 1'b0;

    for (int i = 0; i < 64; i++)
      checkOutput($sformatf("mem[%0d]", i), memArr[i],
                  {refBytes[4 * i + 3], refBytes[4 * i + 2], refBytes[4 * i + 1], refBytes[4 * i]});

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
